// File: rtl/visor_bp_pkg.sv
// Shared types and helpers for the visor breakpoint/single-step engine.
package visor_bp_pkg;

  localparam int unsigned BP_ADDR_W  = 16;
  localparam int unsigned BP_COUNT_W = 8;

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    RESUME,
    STEP
  } bp_state_e;

  typedef struct packed {
    logic [BP_ADDR_W-1:0]  addr;
    logic [BP_COUNT_W-1:0] reload;
    logic                  enable;
    logic                  range;
  } slot_cfg_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/visor_bp_slot.sv
// One breakpoint comparator with pending flag and pass counter.
// VISOR_BP_RANGE_EN adds inclusive range matching for odd/even slot pairs.
module visor_bp_slot
  import visor_bp_pkg::*;
#(
  parameter int unsigned ADDR_W  = BP_ADDR_W,
  parameter int unsigned COUNT_W = BP_COUNT_W
`ifdef VISOR_BP_RANGE_EN
  ,
  parameter bit          ODD     = 1'b0
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  tg_code_addr,
  input  logic               tg_enable_exec,
  input  logic               run_en,
  input  logic               step_en,
  input  logic               clear_pend,
  input  logic               clear_all,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COUNT_W-1:0] wr_count,
  input  logic               wr_enable,
  input  logic               wr_range,
`ifdef VISOR_BP_RANGE_EN
  input  logic [ADDR_W-1:0]  pair_addr,
  input  logic               pair_range,
  output logic [ADDR_W-1:0]  cfg_addr,
  output logic               cfg_range,
`endif
  output logic               evt,
  output logic               hit
);

  slot_cfg_t          cfg_q, cfg_d;
  logic               pend_q, pend_d;
  logic [COUNT_W-1:0] remain_q, remain_d;
  logic               match_raw;
  logic               match_comb;
  logic               pend_live;

`ifdef VISOR_BP_RANGE_EN
  // Odd slot in range mode spans [pair addr, own addr]; its even partner goes quiet.
  always_comb begin
    match_raw = (cfg_q.addr == tg_code_addr);
    if (ODD && cfg_q.range) begin
      match_raw = (pair_addr <= tg_code_addr) && (tg_code_addr <= cfg_q.addr);
    end else if (!ODD && pair_range) begin
      match_raw = 1'b0;
    end
  end

  assign cfg_addr  = cfg_q.addr;
  assign cfg_range = cfg_q.range;
`else
  logic unused_range;

  assign match_raw    = (cfg_q.addr == tg_code_addr);
  assign unused_range = cfg_q.range;
`endif

  assign match_comb = cfg_q.enable && match_raw;
  assign pend_live  = pend_q && !clear_pend;
  assign evt        = tg_enable_exec && (run_en || step_en) && (pend_live || match_comb);
  assign hit        = run_en && evt && (remain_q == '0) && !wr_en;

  always_comb begin
    cfg_d    = cfg_q;
    pend_d   = pend_q;
    remain_d = remain_q;
    if (clear_pend) begin
      pend_d = 1'b0;
    end
    if (run_en && match_comb) begin
      pend_d = 1'b1;
    end
    if (evt) begin
      pend_d = 1'b0;
      if (run_en) begin
        remain_d = (remain_q != '0) ? remain_q - COUNT_W'(1) : cfg_q.reload;
      end
    end
    if (clear_all) begin
      pend_d   = 1'b0;
      remain_d = cfg_q.reload;
    end
    if (wr_en) begin
      cfg_d.addr   = wr_addr;
      cfg_d.reload = wr_count;
      cfg_d.enable = wr_enable;
      cfg_d.range  = wr_range;
      pend_d       = 1'b0;
      remain_d     = wr_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q    <= '0;
      pend_q   <= 1'b0;
      remain_q <= '0;
    end else begin
      cfg_q    <= cfg_d;
      pend_q   <= pend_d;
      remain_q <= remain_d;
    end
  end

endmodule

// File: rtl/visor_bp_unit.sv
// Breakpoint and single-step engine: NUM_BP slots plus halt/resume/step FSM.
// VISOR_BP_RANGE_EN enables paired range breakpoints.
module visor_bp_unit
  import visor_bp_pkg::*;
#(
  parameter int unsigned NUM_BP  = 4,
  parameter int unsigned ADDR_W  = BP_ADDR_W,
  parameter int unsigned COUNT_W = BP_COUNT_W,
  parameter int unsigned IDX_W   = idx_w(NUM_BP)
) (
  input  logic               sysclk,
  input  logic               sysreset_n,
  input  logic [ADDR_W-1:0]  tg_code_addr,
  input  logic               tg_enable_exec,
  input  logic               bp_wr_en,
  input  logic [IDX_W-1:0]   bp_wr_idx,
  input  logic [ADDR_W-1:0]  bp_wr_addr,
  input  logic [COUNT_W-1:0] bp_wr_count,
  input  logic               bp_wr_enable,
  input  logic               bp_wr_range,
  input  logic               step_req,
  input  logic               resume_req,
  input  logic               clear_req,
  output logic               tg_hold,
  output logic               halted,
  output logic [NUM_BP-1:0]  hit_mask,
  output logic               hit_step,
  output logic [ADDR_W-1:0]  hit_addr
);

  bp_state_e          state_q, state_d;
  logic               tg_hold_q, tg_hold_d;
  logic [NUM_BP-1:0]  hit_mask_q, hit_mask_d;
  logic               hit_step_q, hit_step_d;
  logic [ADDR_W-1:0]  hit_addr_q, hit_addr_d;
  logic [NUM_BP-1:0]  evt_v, hit_v, wr_sel;
  logic               resume_hold;
  logic               slot_run;
  logic               clear_pend;

`ifdef VISOR_BP_RANGE_EN
  logic [ADDR_W-1:0]  cfg_addr_v [NUM_BP];
  logic [NUM_BP-1:0]  cfg_range_v;
`endif

  // RESUME behaves like RUN as soon as the target has moved off the halt address.
  assign resume_hold = (state_q == RESUME) && (tg_code_addr == hit_addr_q);
  assign slot_run    = (state_q == RUN) || ((state_q == RESUME) && !resume_hold);

  for (genvar i = 0; i < NUM_BP; i++) begin : g_slot
    assign wr_sel[i] = bp_wr_en && (32'(bp_wr_idx) == i);

`ifdef VISOR_BP_RANGE_EN
    logic [ADDR_W-1:0] pair_addr;
    logic              pair_range;

    if ((i ^ 1) < NUM_BP) begin : g_pair
      assign pair_addr  = cfg_addr_v[i ^ 1];
      assign pair_range = cfg_range_v[i ^ 1];
    end else begin : g_nopair
      assign pair_addr  = '0;
      assign pair_range = 1'b0;
    end
`endif

    visor_bp_slot #(
      .ADDR_W (ADDR_W),
      .COUNT_W(COUNT_W)
`ifdef VISOR_BP_RANGE_EN
      ,
      .ODD    ((i % 2) == 1)
`endif
    ) u_slot (
      .clk           (sysclk),
      .rst_n         (sysreset_n),
      .tg_code_addr  (tg_code_addr),
      .tg_enable_exec(tg_enable_exec),
      .run_en        (slot_run),
      .step_en       (state_q == STEP),
      .clear_pend    (clear_pend),
      .clear_all     (clear_req),
      .wr_en         (wr_sel[i]),
      .wr_addr       (bp_wr_addr),
      .wr_count      (bp_wr_count),
      .wr_enable     (bp_wr_enable),
      .wr_range      (bp_wr_range),
`ifdef VISOR_BP_RANGE_EN
      .pair_addr     (pair_addr),
      .pair_range    (pair_range),
      .cfg_addr      (cfg_addr_v[i]),
      .cfg_range     (cfg_range_v[i]),
`endif
      .evt           (evt_v[i]),
      .hit           (hit_v[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    hit_mask_d = hit_mask_q & ~wr_sel;
    hit_step_d = hit_step_q;
    hit_addr_d = hit_addr_q;
    clear_pend = 1'b0;
    case (state_q)
      RUN, RESUME: begin
        if (slot_run) begin
          clear_pend = (state_q == RESUME);
          state_d    = RUN;
          if (|hit_v) begin
            state_d    = HALTED;
            hit_mask_d = hit_v;
            hit_addr_d = tg_code_addr;
            hit_step_d = 1'b0;
          end
        end
      end
      HALTED: begin
        if (resume_req) begin
          state_d = RESUME;
        end else if (step_req) begin
          state_d = STEP;
        end
      end
      STEP: begin
        if (tg_enable_exec) begin
          state_d    = HALTED;
          hit_mask_d = evt_v & ~wr_sel;
          hit_addr_d = tg_code_addr;
          hit_step_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (clear_req) begin
      state_d    = RUN;
      hit_mask_d = '0;
      hit_step_d = 1'b0;
      clear_pend = 1'b1;
    end
    tg_hold_d = (state_d == HALTED);
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q    <= RUN;
      tg_hold_q  <= 1'b0;
      hit_mask_q <= '0;
      hit_step_q <= 1'b0;
      hit_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      tg_hold_q  <= tg_hold_d;
      hit_mask_q <= hit_mask_d;
      hit_step_q <= hit_step_d;
      hit_addr_q <= hit_addr_d;
    end
  end

  assign tg_hold  = tg_hold_q;
  assign halted   = (state_q == HALTED);
  assign hit_mask = hit_mask_q;
  assign hit_step = hit_step_q;
  assign hit_addr = hit_addr_q;

endmodule

// File: tb/tb_visor_bp_unit.sv
// Directed vector bench for visor_bp_unit (default build or VISOR_BP_RANGE_EN).
module tb_visor_bp_unit;

  localparam int unsigned NUM_BP  = 4;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned COUNT_W = 8;

  logic               sysclk = 1'b0;
  logic               sysreset_n = 1'b0;
  logic [ADDR_W-1:0]  tg_code_addr = '0;
  logic               tg_enable_exec = 1'b0;
  logic               bp_wr_en = 1'b0;
  logic [1:0]         bp_wr_idx = '0;
  logic [ADDR_W-1:0]  bp_wr_addr = '0;
  logic [COUNT_W-1:0] bp_wr_count = '0;
  logic               bp_wr_enable = 1'b0;
  logic               bp_wr_range = 1'b0;
  logic               step_req = 1'b0;
  logic               resume_req = 1'b0;
  logic               clear_req = 1'b0;
  logic               tg_hold;
  logic               halted;
  logic [NUM_BP-1:0]  hit_mask;
  logic               hit_step;
  logic [ADDR_W-1:0]  hit_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sysclk = ~sysclk;

  visor_bp_unit #(
    .NUM_BP (NUM_BP),
    .ADDR_W (ADDR_W),
    .COUNT_W(COUNT_W)
  ) dut (
    .sysclk        (sysclk),
    .sysreset_n    (sysreset_n),
    .tg_code_addr  (tg_code_addr),
    .tg_enable_exec(tg_enable_exec),
    .bp_wr_en      (bp_wr_en),
    .bp_wr_idx     (bp_wr_idx),
    .bp_wr_addr    (bp_wr_addr),
    .bp_wr_count   (bp_wr_count),
    .bp_wr_enable  (bp_wr_enable),
    .bp_wr_range   (bp_wr_range),
    .step_req      (step_req),
    .resume_req    (resume_req),
    .clear_req     (clear_req),
    .tg_hold       (tg_hold),
    .halted        (halted),
    .hit_mask      (hit_mask),
    .hit_step      (hit_step),
    .hit_addr      (hit_addr)
  );

  typedef struct {
    logic [15:0] addr;
    logic        exec;
    logic [2:0]  crs;     // {clear, resume, step}
    logic        wr;
    logic [1:0]  widx;
    logic [15:0] waddr;
    logic [7:0]  wcnt;
    logic        wen;
    logic        wrange;
    logic [1:0]  e_hh;    // {tg_hold, halted}
    logic [3:0]  e_mask;
    logic        e_step;
    logic [15:0] e_haddr;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] a, input logic x, input logic [2:0] crs,
                              input logic w, input logic [1:0] wi, input logic [15:0] wa,
                              input logic [7:0] wc, input logic we, input logic [1:0] hh,
                              input logic [3:0] m, input logic s, input logic [15:0] ha);
    vec_t t;
    t.addr = a; t.exec = x; t.crs = crs; t.wr = w; t.widx = wi; t.waddr = wa;
    t.wcnt = wc; t.wen = we; t.wrange = 1'b0; t.e_hh = hh; t.e_mask = m;
    t.e_step = s; t.e_haddr = ha;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] hh, input logic [3:0] m,
                            input logic s, input logic [15:0] ha);
    check({tag, " tg_hold"}, 32'(tg_hold), 32'(hh[1]));
    check({tag, " halted"}, 32'(halted), 32'(hh[0]));
    check({tag, " hit_mask"}, 32'(hit_mask), 32'(m));
    check({tag, " hit_step"}, 32'(hit_step), 32'(s));
    check({tag, " hit_addr"}, 32'(hit_addr), 32'(ha));
  endtask

  // Inputs are driven 1ns after a rising edge, held for one cycle, outputs checked 1ns after the next edge.
  task automatic run_vec(input vec_t t, input string tag);
    tg_code_addr   = t.addr;
    tg_enable_exec = t.exec;
    {clear_req, resume_req, step_req} = t.crs;
    bp_wr_en       = t.wr;
    bp_wr_idx      = t.widx;
    bp_wr_addr     = t.waddr;
    bp_wr_count    = t.wcnt;
    bp_wr_enable   = t.wen;
    bp_wr_range    = t.wrange;
    @(posedge sysclk);
    #1;
    tg_enable_exec = 1'b0;
    {clear_req, resume_req, step_req} = 3'b000;
    bp_wr_en       = 1'b0;
    bp_wr_range    = 1'b0;
    check_outs(tag, t.e_hh, t.e_mask, t.e_step, t.e_haddr);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    // Exact-match scenarios: halt, resume, step, pass counts, pend, write priority.
    vecs.push_back(mk(16'h0000, 0, 3'b000, 1, 0, 16'h0040, 0, 1, 2'b00, 4'b0000, 0, 16'h0000)); // r0
    vecs.push_back(mk(16'h0040, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0001, 0, 16'h0040));          // r1 hit
    vecs.push_back(mk(16'h0040, 0, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0001, 0, 16'h0040));
    vecs.push_back(mk(16'h0040, 0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 4'b0001, 0, 16'h0040));          // r3 resume
    vecs.push_back(mk(16'h0040, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0001, 0, 16'h0040));          // no re-hit
    vecs.push_back(mk(16'h0042, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0001, 0, 16'h0040));
    vecs.push_back(mk(16'h0044, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0001, 0, 16'h0040));
    vecs.push_back(mk(16'h0040, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0001, 0, 16'h0040));          // r7 re-hit
    vecs.push_back(mk(16'h0040, 0, 3'b001, 0, 0, 0, 0, 0, 2'b00, 4'b0001, 0, 16'h0040));          // r8 step
    vecs.push_back(mk(16'h0042, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 16'h0042));          // step halt
    vecs.push_back(mk(16'h0042, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1, 16'h0042));
    vecs.push_back(mk(16'h0042, 0, 3'b011, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 16'h0042));          // r11 res+step
    vecs.push_back(mk(16'h0044, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 16'h0042));
    vecs.push_back(mk(16'h0012, 1, 3'b000, 1, 1, 16'h0010, 2, 1, 2'b00, 4'b0000, 1, 16'h0042));   // r13
    vecs.push_back(mk(16'h0010, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 16'h0042));          // pass 1
    vecs.push_back(mk(16'h0012, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 16'h0042));
    vecs.push_back(mk(16'h0010, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 16'h0042));          // pass 2
    vecs.push_back(mk(16'h0012, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 1, 16'h0042));
    vecs.push_back(mk(16'h0010, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0010, 0, 16'h0010));          // r18 pass 3
    vecs.push_back(mk(16'h0012, 0, 3'b100, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0010));          // clear
    vecs.push_back(mk(16'h0010, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0010));
    vecs.push_back(mk(16'h0012, 0, 3'b100, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0010));          // r21 reload
    vecs.push_back(mk(16'h0010, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0010));
    vecs.push_back(mk(16'h0010, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0010));
    vecs.push_back(mk(16'h0010, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0010, 0, 16'h0010));          // r24
    vecs.push_back(mk(16'h0000, 0, 3'b100, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0010));
    vecs.push_back(mk(16'h0000, 0, 3'b000, 1, 1, 16'h0010, 0, 1, 2'b00, 4'b0000, 0, 16'h0010));
    vecs.push_back(mk(16'h0010, 0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0010));          // pend set
    vecs.push_back(mk(16'h0020, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0010, 0, 16'h0020));          // pend hit
    vecs.push_back(mk(16'h0000, 0, 3'b100, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0020));
    vecs.push_back(mk(16'h0040, 1, 3'b000, 1, 0, 16'h0040, 1, 1, 2'b00, 4'b0000, 0, 16'h0020));   // r30 wr wins
    vecs.push_back(mk(16'h0042, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0020));
    vecs.push_back(mk(16'h0040, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0020));
    vecs.push_back(mk(16'h0042, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0020));
    vecs.push_back(mk(16'h0040, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0001, 0, 16'h0040));          // r34
    vecs.push_back(mk(16'h0040, 0, 3'b000, 1, 0, 16'h0040, 0, 0, 2'b11, 4'b0000, 0, 16'h0040));   // wr in HALTED
    vecs.push_back(mk(16'h0040, 0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0040));
    vecs.push_back(mk(16'h0040, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0040));
    vecs.push_back(mk(16'h0050, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0040));
    vecs.push_back(mk(16'h0040, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0040));          // disabled
    vecs.push_back(mk(16'h0044, 0, 3'b001, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0040));          // step in RUN
    vecs.push_back(mk(16'h0046, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0040));
    vecs.push_back(mk(16'h0046, 1, 3'b010, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0040));
    vecs.push_back(mk(16'h0000, 0, 3'b000, 1, 2, 16'h0080, 0, 1, 2'b00, 4'b0000, 0, 16'h0040));
    vecs.push_back(mk(16'h0000, 0, 3'b000, 1, 3, 16'h0080, 0, 1, 2'b00, 4'b0000, 0, 16'h0040));
    vecs.push_back(mk(16'h0080, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b1100, 0, 16'h0080));          // two slots
    vecs.push_back(mk(16'h0000, 0, 3'b100, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0080));

    #12;
    check_outs("reset", 2'b00, 4'b0000, 1'b0, 16'h0000);
    @(posedge sysclk);
    #1;
    sysreset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("row%0d", i));
    end

    // Range pairing: slot2 low bound, slot3 high bound with range flag.
    v = mk(16'h0000, 0, 3'b000, 1, 2, 16'h0100, 0, 1, 2'b00, 4'b0000, 0, 16'h0080);
    run_vec(v, "rng_w2");
    v = mk(16'h0000, 0, 3'b000, 1, 3, 16'h01FF, 0, 1, 2'b00, 4'b0000, 0, 16'h0080);
    v.wrange = 1'b1;
    run_vec(v, "rng_w3");
`ifdef VISOR_BP_RANGE_EN
    run_vec(mk(16'h0180, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b1000, 0, 16'h0180), "rng_mid");
    run_vec(mk(16'h0000, 0, 3'b100, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0180), "rng_clr1");
    run_vec(mk(16'h0200, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0180), "rng_above");
    run_vec(mk(16'h0100, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b1000, 0, 16'h0100), "rng_lo");
    run_vec(mk(16'h0000, 0, 3'b100, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0100), "rng_clr2");
    run_vec(mk(16'h01FF, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b1000, 0, 16'h01FF), "rng_hi");
    run_vec(mk(16'h0000, 0, 3'b100, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h01FF), "rng_clr3");
    run_vec(mk(16'h0000, 0, 3'b000, 1, 2, 16'h0300, 0, 1, 2'b00, 4'b0000, 0, 16'h01FF), "rng_inv_w");
    run_vec(mk(16'h0200, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h01FF), "rng_inv_mid");
    run_vec(mk(16'h0300, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h01FF), "rng_inv_lo");
`else
    run_vec(mk(16'h0180, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0080), "exact_mid");
    run_vec(mk(16'h0100, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0100, 0, 16'h0100), "exact_lo");
    run_vec(mk(16'h0000, 0, 3'b100, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0100), "exact_clr");
    run_vec(mk(16'h01FF, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b1000, 0, 16'h01FF), "exact_hi");
    run_vec(mk(16'h0000, 0, 3'b100, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h01FF), "exact_clr2");
`endif

    // Asynchronous reset while HALTED drops the hold immediately and wipes slot config.
    run_vec(mk(16'h0000, 0, 3'b000, 1, 0, 16'h0090, 0, 1, 2'b00, 4'b0000, 0, 16'h01FF), "ar_w0");
    run_vec(mk(16'h0090, 1, 3'b000, 0, 0, 0, 0, 0, 2'b11, 4'b0001, 0, 16'h0090), "ar_halt");
    #2;
    sysreset_n = 1'b0;
    #1;
    check_outs("ar_async", 2'b00, 4'b0000, 1'b0, 16'h0000);
    @(posedge sysclk);
    #1;
    sysreset_n = 1'b1;
    run_vec(mk(16'h0090, 1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0, 16'h0000), "ar_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/visor_bp_unit.md
Name: visor_bp_unit

Overview:
- Parametrised breakpoint and single-step engine for the debug supervisor, placed between the visor register file and the target Synapse316 fetch path.
- Supports NUM_BP address comparators, each with an enable and a pass count.
- A halt/resume/step state machine drives a hold line that gates the target's code_ready.
- Hits are qualified on the target's enable_exec cycles, so halts land only on ordinary assignment cycles and the visor can safely commandeer and refill exr.

Parameters:
NUM_BP, 4, number of breakpoint slots (1..16)
ADDR_W, 16, target code address width
COUNT_W, 8, pass-count width per slot
IDX_W, $clog2(NUM_BP) (minimum 1), slot index width (derived)

Ports:
sysclk  in  1  system clock
sysreset_n  in  1  asynchronous active-low reset
tg_code_addr  in  ADDR_W  target fetch address
tg_enable_exec  in  1  target debug_out enable_exec (qualifying cycle)
bp_wr_en  in  1  write one slot this cycle
bp_wr_idx  in  IDX_W  slot written
bp_wr_addr  in  ADDR_W  slot address
bp_wr_count  in  COUNT_W  matches to pass before hit (0 = hit on first)
bp_wr_enable  in  1  slot enable
bp_wr_range  in  1  range-mode flag (used only under the option)
step_req  in  1  single-cycle pulse: execute one instruction, then halt
resume_req  in  1  single-cycle pulse: leave HALTED
clear_req  in  1  single-cycle pulse: drop all pending and hit state, run
tg_hold  out  1  registered; 1 stalls the target (ANDed into code_ready upstream)
halted  out  1  state == HALTED
hit_mask  out  NUM_BP  slots that caused the current halt
hit_step  out  1  current halt caused by a step
hit_addr  out  ADDR_W  tg_code_addr captured at the hit

Behaviour:
- Reset (async, sysreset_n low): state RUN. All slots disabled with addr 0, reload 0, remain 0, pend 0. All outputs 0.
- Per-slot match_comb = enable && tg_code_addr == addr.
- pend is set on match_comb and cleared when consumed.
- In RUN, a slot event occurs when tg_enable_exec && (pend || match_comb). On an event:
  - remain != 0: decrement remain, clear pend.
  - remain == 0: the slot hits.
- Any hit in a cycle moves to HALTED on the next edge. At that edge: tg_hold=1, hit_mask = OR of hitting slots, hit_addr = tg_code_addr, hit_step=0, and each hitting slot reloads remain from its reload value.
- Latency: the cycle after the qualifying enable_exec shows tg_hold=1.
- HALTED:
  - tg_hold stays 1 and events are ignored.
  - resume_req moves to RESUME: tg_hold=0 next cycle.
  - step_req moves to STEP: tg_hold=0.
- RESUME: matches are suppressed while tg_code_addr == hit_addr, so the target does not re-hit its own halt address. Once the address differs, return to RUN and clear pends.
- STEP: the first tg_enable_exec moves to HALTED with hit_step=1, hit_mask = any slot events in that same cycle, and hit_addr captured.
- Priority: clear_req > resume_req > step_req. When both resume_req and step_req arrive in HALTED, the result is RESUME.
- clear_req in any state: state RUN, tg_hold=0, pend/hit_mask/hit_step cleared, remain reloaded. Slot configuration is kept.
- bp_wr_en (any state): the addressed slot loads addr, reload, and remain=bp_wr_count, and clears its pend and its hit_mask bit. The write wins over a same-cycle event on that slot. A write does not change the state, so HALTED persists.
- bp_wr_idx >= NUM_BP: the write is ignored.
- Decrementing remain never wraps; the zero check precedes the decrement.
- step_req or resume_req outside HALTED: ignored.

Optional Feature:
- Macro: VISOR_BP_RANGE_EN.
- When defined, each odd slot 2k+1 written with range=1 pairs with slot 2k as an inclusive range. The pair matches when addr[2k] <= tg_code_addr <= addr[2k+1] (unsigned), using slot 2k+1's enable and count.
- When a pair is in range mode, slot 2k does not match on its own.
- If addr[2k] > addr[2k+1], the pair never matches.
- When undefined, bp_wr_range is ignored and only exact matching exists.

Decomposition:
- Package visor_bp_pkg holds:
  - state enum {RUN, HALTED, RESUME, STEP}
  - slot_cfg_t struct {addr, reload, enable, range}
  - index-width helper function
- Sub-module visor_bp_slot holds one comparator, pend, and remain counter. The top instantiates it NUM_BP times and owns the FSM and capture registers.

Test Plan:
1. Slot0 addr=0x0040 count=0 enabled; target fetches 0x0040 with enable_exec -> next cycle tg_hold=1, halted=1, hit_mask=0001, hit_addr=0x0040.
2. Slot1 addr=0x0010 count=2; loop passes 0x0010 three times -> no hold on passes 1-2, halt on pass 3. After clear_req, remain is back to 2.
3. Halted at 0x0040, resume_req -> tg_hold=0 next cycle, no re-hit while addr=0x0040, re-hit on the next loop iteration at 0x0040.
4. Halted, step_req -> exactly one enable_exec executes, then halted=1, hit_step=1, hit_mask=0000, hit_addr = next address.
5. Same-cycle resume_req+step_req -> RESUME. bp_wr_en to slot0 in the same cycle as its event -> no hit, remain=new count.
6. With VISOR_BP_RANGE_EN: slot2=0x0100, slot3=0x01FF range=1 -> fetch 0x0180 hits with hit_mask=1000; fetch 0x0200 does not hit. Assert sysreset_n low mid-HALTED -> tg_hold=0 immediately.
